// File: rtl/cache_pkg.sv
// cache_pkg: shared definitions for the split I/D cache controller.
//   - state_e   : controller FSM states (IDLE, WB, WB_GAP, FILL)
//   - SRC_I/D   : encoding of the latched miss requester
//   - defaults and clog2-based helpers for the derived widths
package cache_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WB     = 2'd1,
    WB_GAP = 2'd2,
    FILL   = 2'd3
  } state_e;

  localparam logic SRC_I = 1'b0;
  localparam logic SRC_D = 1'b1;

  localparam int ADDR_W_DEF = 16;
  localparam int WORD_W_DEF = 16;
  localparam int WPL_DEF    = 4;
  localparam int TAG_W_DEF  = 8;

  // Word-offset width inside a line.
  function automatic int off_width(input int words_per_line);
    return $clog2(words_per_line);
  endfunction

  // Line-address width: word address minus the in-line offset.
  function automatic int line_addr_width(input int addr_w, input int words_per_line);
    return addr_w - $clog2(words_per_line);
  endfunction

endpackage

// File: rtl/cache_word_merge.sv
// cache_word_merge: replaces one word of a cache line.
// Ports:
//   line_i   [LINE_W-1:0]  original line
//   word_i   [WORD_W-1:0]  word to insert
//   off_i    [OFF_W-1:0]   word slot; word k lives in [k*WORD_W +: WORD_W]
//   merged_o [LINE_W-1:0]  line with slot off_i replaced by word_i
module cache_word_merge
  import cache_pkg::*;
#(
  parameter int WORD_W         = WORD_W_DEF,
  parameter int WORDS_PER_LINE = WPL_DEF,
  parameter int OFF_W          = off_width(WORDS_PER_LINE),
  parameter int LINE_W         = WORD_W * WORDS_PER_LINE
) (
  input  logic [LINE_W-1:0] line_i,
  input  logic [WORD_W-1:0] word_i,
  input  logic [OFF_W-1:0]  off_i,
  output logic [LINE_W-1:0] merged_o
);

  always_comb begin
    merged_o = line_i;
    merged_o[off_i*WORD_W +: WORD_W] = word_i;
  end

endmodule

// File: rtl/cache_ctrl_param.sv
// cache_ctrl_param: split I/D cache controller in front of a shared,
// line-wide memory port. One miss is served at a time; a data miss wins
// over an instruction miss. Dirty data victims are written back (WB),
// followed by one idle cycle (WB_GAP), then the line is refilled (FILL).
//
// Memory handshake: m_re / m_we is a level request held (with a stable
// m_addr) until memory answers with a single-cycle m_rdy pulse; the two are
// never asserted together, and m_rdy outside WB/FILL is ignored.
//
// Ports:
//   clk, rst_n               clock, synchronous active-low reset
//   re, we, i_fetch          data read/write and fetch requests (levels)
//   i_hit, d_hit             tag-match results
//   d_dirty, d_tag           dirty bit / tag of the indexed D line
//   i_addr, d_addr           word addresses
//   wr_data                  store data
//   i_out, d_out, m_out      indexed I/D lines, memory read line
//   m_rdy                    memory access complete (pulse)
//   stall                    pipeline freeze
//   instr, rd_data           word selected by the address offset
//   i_we/i_data, d_we/d_data/d_dirty_in   array line writes
//   m_re, m_we, m_addr, m_data            memory request
//   dbg_state                current FSM state
// Build option CACHE_PERF_CNT_EN adds saturating counters i_miss_cnt,
// d_miss_cnt, wb_cnt and stall_cnt as extra outputs.
module cache_ctrl_param
  import cache_pkg::*;
#(
  parameter int ADDR_W         = ADDR_W_DEF,
  parameter int WORD_W         = WORD_W_DEF,
  parameter int WORDS_PER_LINE = WPL_DEF,
  parameter int TAG_W          = TAG_W_DEF,
  parameter int LINE_W         = WORD_W * WORDS_PER_LINE,
  localparam int OFF_W         = off_width(WORDS_PER_LINE),
  localparam int LA_W          = line_addr_width(ADDR_W, WORDS_PER_LINE),
  localparam int IDX_W         = LA_W - TAG_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              re,
  input  logic              we,
  input  logic              i_fetch,
  input  logic              i_hit,
  input  logic              d_hit,
  input  logic              d_dirty,
  input  logic [TAG_W-1:0]  d_tag,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [WORD_W-1:0] wr_data,
  input  logic [LINE_W-1:0] i_out,
  input  logic [LINE_W-1:0] d_out,
  input  logic [LINE_W-1:0] m_out,
  input  logic              m_rdy,
  output logic              stall,
  output logic [WORD_W-1:0] instr,
  output logic [WORD_W-1:0] rd_data,
  output logic              i_we,
  output logic              d_we,
  output logic [LINE_W-1:0] i_data,
  output logic [LINE_W-1:0] d_data,
  output logic              d_dirty_in,
  output logic              m_re,
  output logic              m_we,
  output logic [LA_W-1:0]   m_addr,
  output logic [LINE_W-1:0] m_data,
  output state_e            dbg_state
`ifdef CACHE_PERF_CNT_EN
  ,
  output logic [31:0]       i_miss_cnt,
  output logic [31:0]       d_miss_cnt,
  output logic [31:0]       wb_cnt,
  output logic [31:0]       stall_cnt
`endif
);

  state_e              state_q, state_d;
  logic                src_q, src_d;
  logic [LA_W-1:0]     victim_q, victim_d;
  logic [LA_W-1:0]     line_q, line_d;
  logic                store_q, store_d;
  logic [OFF_W-1:0]    off_q, off_d;
  logic [WORD_W-1:0]   wdata_q, wdata_d;

  logic                d_miss, i_miss;
  logic [LA_W-1:0]     d_line, i_line;
  logic [IDX_W-1:0]    d_idx;
  logic [LINE_W-1:0]   hit_line, fill_line;

  assign d_miss = (re | we) & ~d_hit;
  assign i_miss = i_fetch & ~i_hit;
  assign d_line = d_addr[ADDR_W-1:OFF_W];
  assign i_line = i_addr[ADDR_W-1:OFF_W];
  assign d_idx  = d_line[IDX_W-1:0];

  // Store hit: live line merged with live store data.
  cache_word_merge #(
    .WORD_W(WORD_W), .WORDS_PER_LINE(WORDS_PER_LINE), .OFF_W(OFF_W), .LINE_W(LINE_W)
  ) u_hit_merge (
    .line_i(d_out), .word_i(wr_data), .off_i(d_addr[OFF_W-1:0]), .merged_o(hit_line)
  );

  // Store miss: refill line merged with the store captured at miss detection.
  cache_word_merge #(
    .WORD_W(WORD_W), .WORDS_PER_LINE(WORDS_PER_LINE), .OFF_W(OFF_W), .LINE_W(LINE_W)
  ) u_fill_merge (
    .line_i(m_out), .word_i(wdata_q), .off_i(off_q), .merged_o(fill_line)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      src_q    <= SRC_I;
      victim_q <= '0;
      line_q   <= '0;
      store_q  <= 1'b0;
      off_q    <= '0;
      wdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      src_q    <= src_d;
      victim_q <= victim_d;
      line_q   <= line_d;
      store_q  <= store_d;
      off_q    <= off_d;
      wdata_q  <= wdata_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    src_d      = src_q;
    victim_d   = victim_q;
    line_d     = line_q;
    store_d    = store_q;
    off_d      = off_q;
    wdata_d    = wdata_q;
    stall      = 1'b1;
    i_we       = 1'b0;
    d_we       = 1'b0;
    i_data     = m_out;
    d_data     = m_out;
    d_dirty_in = 1'b0;
    m_re       = 1'b0;
    m_we       = 1'b0;
    m_addr     = '0;

    unique case (state_q)
      IDLE: begin
        if (d_miss) begin
          // Everything needed to finish the miss is captured here so that
          // later changes on the request inputs cannot redirect it.
          src_d    = SRC_D;
          victim_d = {d_tag, d_idx};
          line_d   = d_line;
          store_d  = we;
          off_d    = d_addr[OFF_W-1:0];
          wdata_d  = wr_data;
          state_d  = d_dirty ? WB : FILL;
        end else if (i_miss) begin
          src_d   = SRC_I;
          line_d  = i_line;
          store_d = 1'b0;
          state_d = FILL;
        end else begin
          stall = 1'b0;
          if (we) begin
            d_we       = 1'b1;
            d_dirty_in = 1'b1;
            d_data     = hit_line;
          end
        end
      end
      WB: begin
        m_we   = 1'b1;
        m_addr = victim_q;
        if (m_rdy) state_d = WB_GAP;
      end
      WB_GAP: begin
        state_d = FILL;
      end
      FILL: begin
        m_re   = 1'b1;
        m_addr = line_q;
        if (m_rdy) begin
          if (src_q == SRC_I) begin
            i_we = 1'b1;
          end else begin
            d_we       = 1'b1;
            d_data     = store_q ? fill_line : m_out;
            d_dirty_in = store_q;
          end
          // Back to IDLE so the hit signals are re-evaluated on the new line.
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // While reset is held the pipeline stays frozen and nothing is written.
    if (!rst_n) begin
      stall  = 1'b1;
      i_we   = 1'b0;
      d_we   = 1'b0;
      m_re   = 1'b0;
      m_we   = 1'b0;
      m_addr = '0;
    end
  end

  assign instr     = rst_n ? i_out[i_addr[OFF_W-1:0]*WORD_W +: WORD_W] : '0;
  assign rd_data   = rst_n ? d_out[d_addr[OFF_W-1:0]*WORD_W +: WORD_W] : '0;
  assign m_data    = d_out;
  assign dbg_state = state_q;

`ifdef CACHE_PERF_CNT_EN
  logic leave_idle;
  assign leave_idle = (state_q == IDLE) && (state_d != IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      i_miss_cnt <= '0;
      d_miss_cnt <= '0;
      wb_cnt     <= '0;
      stall_cnt  <= '0;
    end else begin
      if (leave_idle && (src_d == SRC_I) && (i_miss_cnt != '1)) i_miss_cnt <= i_miss_cnt + 32'd1;
      if (leave_idle && (src_d == SRC_D) && (d_miss_cnt != '1)) d_miss_cnt <= d_miss_cnt + 32'd1;
      if (leave_idle && (state_d == WB) && (wb_cnt != '1))      wb_cnt     <= wb_cnt + 32'd1;
      if (stall && (stall_cnt != '1))                           stall_cnt  <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_cache_ctrl_param.sv
// tb_cache_ctrl_param: directed + randomized bench for cache_ctrl_param.
// The reference is a word-array view of lines and plain address arithmetic
// (line address = addr / words, offset = addr % words); memory answers the
// third cycle of every request. Build option CACHE_PERF_CNT_EN also checks
// the miss/write-back counters.
module tb_cache_ctrl_param;

  localparam int AW  = 16;
  localparam int WW  = 16;
  localparam int WPL = 4;
  localparam int TW  = 8;
  localparam int LW  = WW * WPL;
  localparam int LAW = 14;
  localparam int LAT = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          re, we, i_fetch, i_hit, d_hit, d_dirty, m_rdy;
  logic [TW-1:0] d_tag;
  logic [AW-1:0] i_addr, d_addr;
  logic [WW-1:0] wr_data;
  logic [LW-1:0] i_out, d_out, m_out;
  logic          stall, i_we, d_we, d_dirty_in, m_re, m_we;
  logic [WW-1:0] instr, rd_data;
  logic [LW-1:0] i_data, d_data, m_data;
  logic [LAW-1:0] m_addr;
  cache_pkg::state_e dbg_state;
`ifdef CACHE_PERF_CNT_EN
  logic [31:0] i_miss_cnt, d_miss_cnt, wb_cnt, stall_cnt;
`endif

  int n_vec = 0;
  int n_err = 0;
  int exp_i_miss = 0;
  int exp_d_miss = 0;
  int exp_wb     = 0;

  always #5 clk = ~clk;

  cache_ctrl_param dut (
    .clk(clk), .rst_n(rst_n), .re(re), .we(we), .i_fetch(i_fetch),
    .i_hit(i_hit), .d_hit(d_hit), .d_dirty(d_dirty), .d_tag(d_tag),
    .i_addr(i_addr), .d_addr(d_addr), .wr_data(wr_data),
    .i_out(i_out), .d_out(d_out), .m_out(m_out), .m_rdy(m_rdy),
    .stall(stall), .instr(instr), .rd_data(rd_data),
    .i_we(i_we), .d_we(d_we), .i_data(i_data), .d_data(d_data),
    .d_dirty_in(d_dirty_in), .m_re(m_re), .m_we(m_we), .m_addr(m_addr),
    .m_data(m_data), .dbg_state(dbg_state)
`ifdef CACHE_PERF_CNT_EN
    , .i_miss_cnt(i_miss_cnt), .d_miss_cnt(d_miss_cnt),
    .wb_cnt(wb_cnt), .stall_cnt(stall_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [LW-1:0] pack(input logic [WW-1:0] w [WPL]);
    logic [LW-1:0] r;
    r = '0;
    for (int k = 0; k < WPL; k++) r[k*WW +: WW] = w[k];
    return r;
  endfunction

  task automatic rand_words(output logic [WW-1:0] w [WPL]);
    for (int k = 0; k < WPL; k++) w[k] = WW'($urandom);
  endtask

  // One complete miss: detection, optional write-back + gap, refill, re-check.
  task automatic do_miss(input bit is_i, input bit is_store, input bit dirty,
                         input logic [AW-1:0] addr, input logic [TW-1:0] tag,
                         input logic [WW-1:0] wd);
    logic [WW-1:0]  mw [WPL];
    logic [WW-1:0]  ew [WPL];
    logic [LW-1:0]  mline, eline;
    logic [LAW-1:0] line_a, vict;
    int             off;
    bit             pending_i;
    off       = int'(addr) % WPL;
    line_a    = LAW'(int'(addr) / WPL);
    vict      = LAW'(int'(tag) * 64 + int'(line_a) % 64);
    pending_i = i_fetch && !i_hit;
    rand_words(mw);
    ew = mw;
    if (is_store) ew[off] = wd;
    mline = pack(mw);
    eline = pack(ew);

    if (is_i) begin
      i_fetch = 1'b1; i_hit = 1'b0; i_addr = addr;
      exp_i_miss++;
    end else begin
      re = !is_store; we = is_store; d_hit = 1'b0; d_dirty = dirty;
      d_tag = tag; d_addr = addr; wr_data = wd;
      exp_d_miss++;
      if (dirty) exp_wb++;
    end
    #1;
    chk("miss_stall", stall, 1'b1);
    chk("miss_no_mem", {m_re, m_we, d_we, i_we}, 4'b0);
    step();

    // Live request inputs now wander; only the captured miss may be served.
    if (is_i) i_addr = AW'($urandom);
    else begin d_addr = AW'($urandom); d_tag = TW'($urandom); end

    if (!is_i && dirty) begin
      for (int c = 1; c <= LAT; c++) begin
        m_rdy = (c == LAT);
        #1;
        chk("wb_req", {m_we, m_re, stall}, 3'b101);
        chk("wb_addr", m_addr, vict);
        step();
        m_rdy = 1'b0;
      end
      m_rdy = 1'b1;  // stray pulse during the gap must be ignored
      #1;
      chk("gap_idle", {m_we, m_re, stall}, 3'b001);
      step();
      m_rdy = 1'b0;
    end

    for (int c = 1; c <= LAT; c++) begin
      m_rdy = (c == LAT);
      m_out = (c == LAT) ? mline : {$urandom, $urandom};
      #1;
      chk("fill_req", {m_re, m_we, stall}, 3'b101);
      chk("fill_addr", m_addr, line_a);
      if (c < LAT) chk("fill_no_wr", {i_we, d_we}, 2'b00);
      else if (is_i) begin
        chk("fill_i_we", {i_we, d_we}, 2'b10);
        chk("fill_i_data", i_data, mline);
      end else begin
        chk("fill_d_we", {d_we, i_we}, 2'b10);
        chk("fill_d_data", d_data, eline);
        chk("fill_d_dirty", d_dirty_in, is_store);
      end
      step();
      m_rdy = 1'b0;
    end

    // Array now holds the line: the request hits on the re-check.
    if (is_i) begin
      i_addr = addr; i_hit = 1'b1; i_out = mline;
      #1;
      chk("post_i_stall", stall, 1'b0);
      chk("post_i_instr", instr, mw[off]);
      i_fetch = 1'b0;
      step();
    end else begin
      d_addr = addr; d_hit = 1'b1; d_out = eline;
      #1;
      if (!pending_i) begin
        chk("post_d_stall", stall, 1'b0);
        if (is_store) chk("post_st_hit", {d_we, d_dirty_in}, 2'b11);
        else          chk("post_ld_data", rd_data, ew[off]);
        re = 1'b0; we = 1'b0;
        step();
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [WW-1:0] w [WPL];
    logic [WW-1:0] ew [WPL];
    logic [WW-1:0] iw [WPL];
    logic [AW-1:0] a, ia;
    logic [WW-1:0] wd;
    int off, ioff;

    // ---- reset with busy-looking inputs: outputs must be forced ----
    rst_n = 1'b0; re = 1'b1; we = 1'b1; i_fetch = 1'b1; i_hit = 1'b0;
    d_hit = 1'b0; d_dirty = 1'b1; d_tag = 8'hFF; i_addr = 16'h0001;
    d_addr = 16'h0002; wr_data = 16'h1234; i_out = {4{16'hCAFE}};
    d_out = {4{16'hD00D}}; m_out = '0; m_rdy = 1'b1;
    step(); step();
    chk("rst_stall", stall, 1'b1);
    chk("rst_en", {i_we, d_we, m_re, m_we}, 4'b0);
    chk("rst_addr", m_addr, '0);
    chk("rst_words", {instr, rd_data}, '0);
    re = 1'b0; we = 1'b0; i_fetch = 1'b0; d_dirty = 1'b0; m_rdy = 1'b0;
    rst_n = 1'b1;
    #1;
    chk("rst_rel_idle", {stall, m_re, m_we}, 3'b000);
    step();

    // ---- scenario 1: load hit at d_addr 0x0012 (word 2) ----
    rand_words(w); w[2] = 16'hBEEF;
    d_out = pack(w); d_addr = 16'h0012; re = 1'b1; d_hit = 1'b1;
    m_rdy = 1'b1;  // stray pulse in IDLE
    #1;
    chk("ld_hit_data", rd_data, 16'hBEEF);
    chk("ld_hit_ctl", {stall, m_re, m_we, d_we}, 4'b0);
    step();
    m_rdy = 1'b0;
    #1;
    chk("idle_rdy_ignored", {stall, m_re, m_we}, 3'b000);

    // ---- random hits: loads, fetches, stores ----
    for (int n = 0; n < 6; n++) begin
      rand_words(w); rand_words(iw);
      a = AW'($urandom); ia = AW'($urandom); wd = WW'($urandom);
      off = int'(a) % WPL; ioff = int'(ia) % WPL;
      ew = w; ew[off] = wd;
      d_out = pack(w); i_out = pack(iw); d_addr = a; i_addr = ia;
      i_fetch = 1'b1; i_hit = 1'b1; d_hit = 1'b1; wr_data = wd;
      re = (n % 2 == 0); we = (n % 2 == 1);
      #1;
      chk("hit_stall", stall, 1'b0);
      chk("hit_rd", rd_data, w[off]);
      chk("hit_instr", instr, iw[ioff]);
      if (we) begin
        chk("st_hit_we", {d_we, d_dirty_in}, 2'b11);
        chk("st_hit_data", d_data, pack(ew));
      end else chk("ld_hit_no_we", d_we, 1'b0);
      step();
    end
    re = 1'b0; we = 1'b0; i_fetch = 1'b0;
    step();

    // ---- scenario 2: clean load miss ----
    do_miss(1'b0, 1'b0, 1'b0, 16'hF00D, 8'h00, 16'h0000);
    // ---- scenario 3: dirty store miss ----
    do_miss(1'b0, 1'b1, 1'b1, 16'h1236, 8'hA5, 16'h5555);
    // ---- scenario 4: fetch and load miss together; data first ----
    ia = AW'($urandom);
    i_fetch = 1'b1; i_hit = 1'b0; i_addr = ia;
    do_miss(1'b0, 1'b0, 1'b0, AW'($urandom), TW'($urandom), WW'($urandom));
    do_miss(1'b1, 1'b0, 1'b0, ia, 8'h00, 16'h0000);
    re = 1'b0; we = 1'b0;
    step();
`ifdef CACHE_PERF_CNT_EN
    chk("cnt_d_miss_s4", d_miss_cnt, 32'd3);
    chk("cnt_i_miss_s4", i_miss_cnt, 32'd1);
    chk("cnt_wb_s4", wb_cnt, 32'd1);
`endif

    // ---- randomized misses ----
    for (int n = 0; n < 6; n++)
      do_miss(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              AW'($urandom), TW'($urandom), WW'($urandom));
    for (int n = 0; n < 3; n++)
      do_miss(1'b1, 1'b0, 1'b0, AW'($urandom), 8'h00, 16'h0000);
`ifdef CACHE_PERF_CNT_EN
    chk("cnt_d_miss", d_miss_cnt, 32'(exp_d_miss));
    chk("cnt_i_miss", i_miss_cnt, 32'(exp_i_miss));
    chk("cnt_wb", wb_cnt, 32'(exp_wb));
`endif

    // ---- scenario 5: reset in the middle of FILL ----
    a = AW'($urandom);
    re = 1'b1; d_hit = 1'b0; d_dirty = 1'b0; d_addr = a;
    step();
    #1;
    chk("rst_fill_req", m_re, 1'b1);
    chk("rst_fill_addr", m_addr, LAW'(int'(a) / WPL));
    rst_n = 1'b0; m_rdy = 1'b1; m_out = {$urandom, $urandom};
    #1;
    chk("rst_fill_forced", {stall, m_re, m_we, d_we, i_we}, 5'b10000);
    chk("rst_fill_words", {m_addr, rd_data}, '0);
    step();
    m_rdy = 1'b0;
`ifdef CACHE_PERF_CNT_EN
    chk("cnt_after_rst", {i_miss_cnt, d_miss_cnt, wb_cnt}, '0);
`endif
    rst_n = 1'b1; re = 1'b0;
    #1;
    chk("rst_fill_idle", {stall, m_re, m_we}, 3'b000);
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
